i2s_frame_sequencer: RTL and testbench
======================================

Name: i2s_frame_sequencer

Overview:
- Takes one snapshot of all I2S capture channels (4 data inputs x L/R = 8 channels) per word-clock frame.
- Sends the enabled channels one at a time, in order, to the USB stream writer over a valid/ready handshake.
- Each word is tagged with a channel index and a frame ID.
- Sits between the I2S_Data instances and the USB FIFO writer, in the USB clock domain; the frame strobe is already synchronized.

Parameters:
- NUM_CH, 8, number of channels; channel index c maps to din[c/2], L if c even, R if c odd.
- WIDTH, 24, sample width in bits.
- CH_W, 3, channel index width; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  input  1  USB interface clock (IFCLK domain).
- rst  input  1  asynchronous, active-high reset.
- frame_stb  input  1  one-cycle pulse: new frame captured, ch_data stable.
- ch_data  input  NUM_CH*WIDTH  flattened samples; channel c is at [c*WIDTH +: WIDTH].
- ch_en  input  NUM_CH  channel enable mask; sampled at frame_stb.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  sample.
- out_chan  output  CH_W  channel index of out_data.
- out_frame  output  8  frame ID of the current frame.
- out_last  output  1  high on the last word of a frame.
- busy  output  1  a frame is being sent.
- overrun_cnt  output  8  count of dropped frames; saturates at 255.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, out_frame=0, out_last=0, busy=0, overrun_cnt=0; state=IDLE; frame ID register=0.
- States: IDLE, LOAD, SEND.
- IDLE:
  - frame_stb=1 and ch_en!=0: copy ch_data into a shadow buffer, latch mask=ch_en, go to LOAD.
  - frame_stb=1 and ch_en==0: ignore the frame; frame ID does not change.
- LOAD (1 cycle): pick the lowest set mask bit as the channel pointer, drive out_* from the shadow buffer, set out_valid=1, go to SEND.
  - Latency: frame_stb to first out_valid is exactly 2 cycles.
- SEND:
  - Outputs hold stable while out_valid=1 and out_ready=0.
  - On handshake (out_valid & out_ready): clear that mask bit; present the next lowest set bit on the next cycle (no bubble).
  - If no bits remain: out_valid=0, frame ID increments (wraps 255->0), go to IDLE.
  - Back-to-back frames: one-cycle IDLE gap minimum.
- out_last=1 when the presented channel is the highest set bit of the latched mask.
- out_frame equals the frame ID for every word of a frame; the first frame after reset is ID 0.
- busy=1 in LOAD and SEND.
- frame_stb while busy: frame dropped; overrun_cnt increments (saturating at 255); the current frame continues unaffected.
- frame_stb in the same cycle as the final handshake: counts as busy, so the frame is dropped and counted.
- ch_data and ch_en changes after the strobe have no effect on the frame in flight.
- ch_en with a single bit set: that one word has out_last=1.
- Reset mid-frame: outputs return to reset values immediately; the shadow buffer contents are don't-care.

Optional Feature:
- Macro: I2S_SEQ_HEADER_EN.
- Defined:
  - LOAD first presents a header word with out_chan=all-ones and out_data={mask zero-padded to 16 bits, frame ID 8 bits} (WIDTH=24).
  - Samples follow the header; the header counts for handshake but never carries out_last.
  - Latency to the first sample word becomes 2 cycles plus the header handshake.
- Undefined: no header word; behaviour as above.

Test Plan:
- ch_en=8'hFF, ch_data[c]=24'h0C0000+c, out_ready=1 -> 8 consecutive words, chan 0..7, data 0C0000..0C0007, out_last only on chan 7, out_frame=0, first valid 2 cycles after strobe.
- ch_en=8'b1010_0100, out_ready toggling 1/0 -> words chan 2,5,7 only; data held stable during stalls; out_last on chan 7.
- Second frame_stb 3 cycles into a frame with out_ready=0 -> overrun_cnt=1; the current frame completes intact; the next frame carries out_frame=1.
- 256 full frames followed by one more -> out_frame goes 255 then 0; 300 forced overruns -> overrun_cnt holds at 255.
- rst asserted during word 4 of 8 -> out_valid drops asynchronously; the next strobe after release sends a full frame with out_frame=0.
- With I2S_SEQ_HEADER_EN, ch_en=8'h03, third frame -> header out_data=24'h000302, out_chan=7, followed by chan 0 and chan 1 (out_last on chan 1).

Source files
------------

// File: rtl/i2s_frame_sequencer_if.sv
// Output word stream from i2s_frame_sequencer to the USB FIFO writer.
//   master : drives out_valid, out_data, out_chan, out_frame, out_last; samples out_ready
//   slave  : the consumer side of the same handshake
interface i2s_frame_sequencer_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CH_W  = 3
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CH_W-1:0]  out_chan;
  logic [7:0]       out_frame;
  logic             out_last;

  modport master (
    output out_valid, out_data, out_chan, out_frame, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_chan, out_frame, out_last,
    output out_ready
  );
endinterface

// File: rtl/i2s_frame_sequencer.sv
// i2s_frame_sequencer: snapshots all I2S capture channels on each frame strobe and
// streams the enabled ones, lowest channel first, over a valid/ready handshake,
// each word tagged with its channel index and a frame ID.
// Ports:
//   clk, rst      IFCLK clock, asynchronous active-high reset
//   frame_stb     one-cycle pulse, ch_data/ch_en valid (already synchronised)
//   ch_data       NUM_CH samples, channel c at [c*WIDTH +: WIDTH]
//   ch_en         channel enable mask, sampled with frame_stb
//   out_if        master side of the output word stream
//   busy          a frame is being loaded or sent
//   overrun_cnt   frames dropped because a strobe arrived while busy (saturating)
// Optional feature: define I2S_SEQ_HEADER_EN to prefix every frame with a header word
// (out_chan all-ones, out_data = {mask zero-padded to 16 bits, frame ID}).
module i2s_frame_sequencer #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned CH_W   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_stb,
  input  logic [NUM_CH*WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]       ch_en,
  i2s_frame_sequencer_if.master   out_if,
  output logic                    busy,
  output logic [7:0]              overrun_cnt
);

  typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

  state_e                  state_q, state_d;
  logic [NUM_CH*WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [7:0]              frame_id_q, frame_id_d;
  logic [7:0]              overrun_q, overrun_d;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [CH_W-1:0]         out_chan_q, out_chan_d;
  logic                    out_last_q, out_last_d;
`ifdef I2S_SEQ_HEADER_EN
  logic                    hdr_q, hdr_d;  // header word is the one being presented
`endif

  logic [NUM_CH-1:0] retire_mask;  // mask left once the presented word is accepted
  logic [NUM_CH-1:0] pick_src;
  logic [CH_W-1:0]   pick;
  logic [NUM_CH-1:0] pick_onehot;

  function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    lowest_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_ch = CH_W'(i);
    end
  endfunction

  always_comb begin
`ifdef I2S_SEQ_HEADER_EN
    // The header's all-ones channel tag aliases a real channel, so it must not clear a bit.
    retire_mask = hdr_q ? mask_q : (mask_q & ~(NUM_CH'(1) << out_chan_q));
`else
    retire_mask = mask_q & ~(NUM_CH'(1) << out_chan_q);
`endif
    pick_src    = (state_q == StLoad) ? mask_q : retire_mask;
    pick        = lowest_ch(pick_src);
    pick_onehot = NUM_CH'(1) << pick;
  end

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    mask_d      = mask_q;
    frame_id_d  = frame_id_q;
    overrun_d   = overrun_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_last_d  = out_last_q;
`ifdef I2S_SEQ_HEADER_EN
    hdr_d       = hdr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (frame_stb && (ch_en != '0)) begin
          shadow_d = ch_data;
          mask_d   = ch_en;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        state_d     = StSend;
        out_valid_d = 1'b1;
`ifdef I2S_SEQ_HEADER_EN
        hdr_d       = 1'b1;
        out_chan_d  = '1;
        out_data_d  = WIDTH'({16'(mask_q), frame_id_q});
        out_last_d  = 1'b0;
`else
        out_chan_d  = pick;
        out_data_d  = shadow_q[pick*WIDTH +: WIDTH];
        out_last_d  = (pick_src & ~pick_onehot) == '0;
`endif
      end
      StSend: begin
        if (out_valid_q && out_if.out_ready) begin
          mask_d = retire_mask;
`ifdef I2S_SEQ_HEADER_EN
          hdr_d  = 1'b0;
`endif
          if (retire_mask != '0) begin
            out_chan_d = pick;
            out_data_d = shadow_q[pick*WIDTH +: WIDTH];
            out_last_d = (pick_src & ~pick_onehot) == '0;
          end else begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            frame_id_d  = frame_id_q + 8'd1;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A strobe while loading or sending (including the final handshake cycle) is dropped.
    if (frame_stb && (state_q != StIdle) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      shadow_q    <= '0;
      mask_q      <= '0;
      frame_id_q  <= '0;
      overrun_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef I2S_SEQ_HEADER_EN
      hdr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      mask_q      <= mask_d;
      frame_id_q  <= frame_id_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_last_q  <= out_last_d;
`ifdef I2S_SEQ_HEADER_EN
      hdr_q       <= hdr_d;
`endif
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_chan  = out_chan_q;
  assign out_if.out_frame = frame_id_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = (state_q != StIdle);
  assign overrun_cnt      = overrun_q;

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Bench for i2s_frame_sequencer: directed sequence with randomised data, masks and
// ready patterns, checked against a per-frame word list built from the channel mask.
module tb_i2s_frame_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_stb = 1'b0;
  logic [191:0] ch_data = '0;
  logic [7:0]   ch_en = '0;
  logic         busy;
  logic [7:0]   overrun_cnt;

  i2s_frame_sequencer_if #(.WIDTH(24), .CH_W(3)) bus ();

  i2s_frame_sequencer #(.NUM_CH(8), .WIDTH(24), .CH_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_stb   (frame_stb),
    .ch_data     (ch_data),
    .ch_en       (ch_en),
    .out_if      (bus),
    .busy        (busy),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] fid_m = 8'd0;  // expected frame ID of the next sent frame
  logic [7:0] ovr_m = 8'd0;  // expected overrun count

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] rand_data();
    logic [191:0] d;
    for (int c = 0; c < 8; c++) d[c*24 +: 24] = 24'($urandom);
    return d;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Strobe a frame from IDLE, scramble the inputs afterwards and check the latency.
  task automatic start_frame(input logic [7:0] m, input logic [191:0] d);
    frame_stb = 1'b1;
    ch_en     = m;
    ch_data   = d;
    tick();
    frame_stb = 1'b0;
    ch_en     = 8'($urandom);
    ch_data   = rand_data();
    if (m == 8'd0) begin
      check("zero_mask_idle", 32'(busy), 32'd0);
    end else begin
      check("lat1_valid", 32'(bus.out_valid), 32'd0);
      check("lat1_busy", 32'(busy), 32'd1);
      tick();
      check("lat2_valid", 32'(bus.out_valid), 32'd1);
    end
  endtask

  // mode 0: ready always 1, mode 1: ready toggles starting at 1, mode 2: random ready.
  // stb_last: pulse frame_stb on the final handshake edge.
  task automatic collect(input logic [7:0] m, input logic [191:0] d, input int mode,
                         input bit stb_last);
    logic [2:0]  exp_chan[$];
    logic [23:0] exp_data[$];
    logic        exp_last[$];
    int          idx = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    bit          r;
    logic [2:0]  sv_chan = '0;
    logic [23:0] sv_data = '0;
    logic        sv_last = 1'b0;
`ifdef I2S_SEQ_HEADER_EN
    exp_chan.push_back(3'd7);
    exp_data.push_back({16'(m), fid_m});
    exp_last.push_back(1'b0);
`endif
    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        exp_chan.push_back(3'(c));
        exp_data.push_back(d[c*24 +: 24]);
        exp_last.push_back((m >> (c + 1)) == 8'd0);
      end
    end
    while (idx < exp_chan.size() && cyc < 400) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.out_ready = r;
      check("no_bubble_valid", 32'(bus.out_valid), 32'd1);
      if (stalled) begin
        check("hold_chan", 32'(bus.out_chan), 32'(sv_chan));
        check("hold_data", 32'(bus.out_data), 32'(sv_data));
        check("hold_last", 32'(bus.out_last), 32'(sv_last));
      end
      if (bus.out_valid) begin
        if (r) begin
          check("word_chan", 32'(bus.out_chan), 32'(exp_chan[idx]));
          check("word_data", 32'(bus.out_data), 32'(exp_data[idx]));
          check("word_last", 32'(bus.out_last), 32'(exp_last[idx]));
          check("word_frame", 32'(bus.out_frame), 32'(fid_m));
          if (stb_last && idx == exp_chan.size() - 1) begin
            frame_stb = 1'b1;
            ovr_m     = sat_inc(ovr_m);
          end
          idx++;
        end
        stalled = !r;
        sv_chan = bus.out_chan;
        sv_data = bus.out_data;
        sv_last = bus.out_last;
      end
      tick();
      frame_stb = 1'b0;
      cyc++;
    end
    check("frame_words", 32'(idx), 32'(exp_chan.size()));
    check("end_valid", 32'(bus.out_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("overrun", 32'(overrun_cnt), 32'(ovr_m));
    fid_m = fid_m + 8'd1;
  endtask

  initial begin
    logic [191:0] d;
    logic [7:0]   m;

    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_chan", 32'(bus.out_chan), 32'd0);
    check("rst_frame", 32'(bus.out_frame), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // All channels, ramp data, ready held high.
    for (int c = 0; c < 8; c++) d[c*24 +: 24] = 24'h0C0000 + 24'(c);
    bus.out_ready = 1'b1;
    start_frame(8'hFF, d);
    collect(8'hFF, d, 0, 1'b0);

    // Sparse mask with a toggling consumer.
    d = rand_data();
    start_frame(8'b1010_0100, d);
    collect(8'b1010_0100, d, 1, 1'b0);

    // Empty mask is ignored and does not advance the frame ID.
    start_frame(8'h00, rand_data());
    tick();
    check("zero_mask_still_idle", 32'(busy), 32'd0);

    // Strobe three cycles into a stalled frame is dropped.
    bus.out_ready = 1'b0;
    d = rand_data();
    start_frame(8'hFF, d);
    tick();
    frame_stb = 1'b1;
    ch_en     = 8'hFF;
    ch_data   = rand_data();
    tick();
    frame_stb = 1'b0;
    ovr_m     = sat_inc(ovr_m);
    check("overrun_one", 32'(overrun_cnt), 32'd1);
    collect(8'hFF, d, 2, 1'b0);

    // Single channel, strobe coinciding with the final handshake.
    d = rand_data();
    bus.out_ready = 1'b1;
    start_frame(8'h10, d);
    collect(8'h10, d, 2, 1'b1);

    // Many random frames, crossing the frame ID wrap.
    for (int f = 0; f < 260; f++) begin
      m = 8'($urandom);
      d = rand_data();
      start_frame(m, d);
      if (m != 8'd0) collect(m, d, 2, ($urandom_range(0, 7) == 0));
    end

    // Saturate the overrun counter.
    bus.out_ready = 1'b0;
    d = rand_data();
    start_frame(8'h81, d);
    for (int i = 0; i < 300; i++) begin
      frame_stb = 1'b1;
      tick();
      ovr_m = sat_inc(ovr_m);
    end
    frame_stb = 1'b0;
    check("overrun_sat", 32'(overrun_cnt), 32'd255);
    collect(8'h81, d, 0, 1'b0);

    // Reset in the middle of a frame.
    bus.out_ready = 1'b1;
    d = rand_data();
    start_frame(8'hFF, d);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_data", 32'(bus.out_data), 32'd0);
    check("midrst_chan", 32'(bus.out_chan), 32'd0);
    check("midrst_frame", 32'(bus.out_frame), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_overrun", 32'(overrun_cnt), 32'd0);
    fid_m = 8'd0;
    ovr_m = 8'd0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    d = rand_data();
    start_frame(8'hFF, d);
    collect(8'hFF, d, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
